// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: rate-1/2 convolutional encoder with 2/3 and 3/4 puncturing and a serial coded-bit output.
// Define CONV_TAIL_INSERT_EN to append K-1 zero tail bits automatically after in_last_i.
module conv_encoder_punct #(
  parameter int K = 7,
  parameter logic [K-1:0] G0 = 7'o133,
  parameter logic [K-1:0] G1 = 7'o171
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rate_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic       in_bit_i,
  input  logic       in_last_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_bit_o,
  output logic       out_last_o
);
  typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;
  state_t state_q, state_d;
  logic [K-2:0] sreg_q, sreg_d;
  logic [K-1:0] vec;
  logic [1:0] p_q, p_d, p_inc, rate_q, rate_d, keep_q, keep_d, eff_rate, period, mask;
  logic a_q, a_d, b_q, b_d, last_q, last_d;
  logic room, acc, load, x, tail_ld, tail_end, is_last;
`ifdef CONV_TAIL_INSERT_EN
  localparam int TW = $clog2(K);
  localparam state_t LAST_ST = TAIL;
  logic [TW-1:0] tail_cnt_q;
  assign tail_ld = state_q == TAIL && room;
  assign tail_end = tail_ld && tail_cnt_q == TW'(K-2);
  assign is_last = tail_end;
  always_ff @(posedge clk)
    tail_cnt_q <= (rst || state_q != TAIL) ? '0 : tail_cnt_q + TW'(tail_ld);
`else
  localparam state_t LAST_ST = DRAIN;
  assign tail_ld = 1'b0;
  assign tail_end = 1'b0;
  assign is_last = acc && in_last_i;
`endif
  // out_last marks the final pending bit of the pair that closes the packet
  assign out_valid_o = |keep_q;
  assign out_bit_o = keep_q[1] ? a_q : b_q;
  assign out_last_o = last_q && (keep_q == 2'b01 || keep_q == 2'b10);
  assign room = keep_q == 2'b00 || (keep_q != 2'b11 && out_ready_i);
  assign in_ready_o = !rst && (state_q == IDLE || state_q == DATA) && room;
  assign acc = in_valid_i && in_ready_o;
  assign load = acc || tail_ld;
  assign x = in_bit_i && state_q != TAIL;
  assign vec = {x, sreg_q};
  always_comb begin
    eff_rate = state_q == IDLE ? rate_i : rate_q;
    period = eff_rate == 2'd1 ? 2'd2 : eff_rate == 2'd2 ? 2'd3 : 2'd1;
    mask = p_q == 2'd0 ? 2'b11 : p_q == 2'd1 ? 2'b10 : 2'b01;
    p_inc = p_q + 2'd1;
    keep_d = load ? mask : (out_valid_o && out_ready_i) ? {1'b0, &keep_q} : keep_q;
    a_d = load ? ^(G0 & vec) : a_q;
    b_d = load ? ^(G1 & vec) : b_q;
    last_d = load ? is_last : last_q;
    p_d = load ? (p_inc == period ? 2'd0 : p_inc) : p_q;
    sreg_d = load ? vec[K-1:1] : sreg_q;
    rate_d = (state_q == IDLE && acc) ? rate_i : rate_q;
    state_d = state_q;
    if (acc) state_d = in_last_i ? LAST_ST : DATA;
    if (tail_end) state_d = DRAIN;
    if (state_q == DRAIN && keep_d == 2'b00) begin
      state_d = IDLE;
      sreg_d = '0;
      p_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q <= '0;
      p_q <= '0;
      rate_q <= '0;
      keep_q <= '0;
      a_q <= 1'b0;
      b_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      p_q <= p_d;
      rate_q <= rate_d;
      keep_q <= keep_d;
      a_q <= a_d;
      b_q <= b_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_conv_encoder_punct.sv
// tb_conv_encoder_punct: randomized self-checking bench against a history-based convolution model.
module tb_conv_encoder_punct;
  localparam int K = 7;
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;
  typedef bit bq_t[$];
  logic clk = 0, rst = 1, in_valid_i = 0, in_bit_i = 0, in_last_i = 0, out_ready_i = 1;
  logic [1:0] rate_i = 0;
  logic in_ready_o, out_valid_o, out_bit_o, out_last_o;
  int checks = 0, errors = 0;
  bit exp_b[$], exp_l[$], got[$];
  logic [7:0] pk;
  conv_encoder_punct dut (
    .clk(clk), .rst(rst), .rate_i(rate_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_bit_i(in_bit_i), .in_last_i(in_last_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_bit_o(out_bit_o), .out_last_o(out_last_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bq_t rbits(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(1)));
    return q;
  endfunction
  // coded bit n is the generator-weighted parity of the input history; puncture by n mod period
  function automatic void build_exp(input bq_t bits, input int r);
    bq_t s = bits;
    int per, ph;
    bit a, b;
`ifdef CONV_TAIL_INSERT_EN
    for (int i = 0; i < K-1; i++) s.push_back(1'b0);
`endif
    per = r == 1 ? 2 : r == 2 ? 3 : 1;
    exp_b = {};
    exp_l = {};
    for (int n = 0; n < s.size(); n++) begin
      a = 0;
      b = 0;
      for (int j = 0; j < K; j++)
        if (n - j >= 0) begin
          a ^= G0[K-1-j] & s[n-j];
          b ^= G1[K-1-j] & s[n-j];
        end
      ph = n % per;
      if (!(per == 3 && ph == 2)) begin exp_b.push_back(a); exp_l.push_back(1'b0); end
      if (per == 1 || ph == 0 || (per == 3 && ph == 2)) begin exp_b.push_back(b); exp_l.push_back(1'b0); end
    end
    exp_l[exp_l.size()-1] = 1'b1;
  endfunction
  task automatic run_pkt(input bq_t bits, input int r, input int r_later, input int stall_pct);
    int idx = 0, cyc = 0, bubbles = 0;
    bit started = 0, stalled = 0, sb = 0, sl = 0, eb, el;
    build_exp(bits, r);
    got = {};
    while (exp_b.size() > 0 && cyc < 4000) begin
      @(negedge clk);
      rate_i = idx == 0 ? 2'(r) : 2'(r_later);
      out_ready_i = $urandom_range(99) >= stall_pct;
      in_valid_i = idx < bits.size();
      in_bit_i = in_valid_i ? bits[idx] : 1'b0;
      in_last_i = idx == bits.size() - 1;
      #1;
      if (stalled) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_bit", out_bit_o, sb);
        check("stall_last", out_last_o, sl);
      end
      if (in_ready_o && out_valid_o) check("ready_full", out_ready_i, 1);
      if (started && !out_valid_o) bubbles++;
      if (out_valid_o) started = 1;
      if (out_valid_o && out_ready_i) begin
        eb = exp_b.pop_front();
        el = exp_l.pop_front();
        check("out_bit", out_bit_o, eb);
        check("out_last", out_last_o, el);
        got.push_back(out_bit_o);
      end
      stalled = out_valid_o && !out_ready_i;
      sb = out_bit_o;
      sl = out_last_o;
      if (in_valid_i && in_ready_o) idx++;
      cyc++;
      @(posedge clk);
    end
    check("timeout", exp_b.size(), 0);
    if (stall_pct == 0) check("bubbles", bubbles, 0);
    @(negedge clk);
    in_valid_i = 0;
    in_last_i = 0;
    out_ready_i = 1;
    #1;
    check("idle_ready", in_ready_o, 1);
    check("idle_valid", out_valid_o, 0);
    @(posedge clk);
  endtask
  initial begin
    @(negedge clk);
    #1;
    check("rst_ready", in_ready_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_bit", out_bit_o, 0);
    check("rst_last", out_last_o, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("post_rst_ready", in_ready_o, 1);
    run_pkt('{1, 0, 1, 1}, 0, 0, 0);
`ifndef CONV_TAIL_INSERT_EN
    pk = '0;
    foreach (got[i]) pk = {pk[6:0], got[i]};
    check("r12_literal", pk, 8'hD1);
`endif
    run_pkt('{1, 0, 1}, 2, 2, 0);
`ifndef CONV_TAIL_INSERT_EN
    pk = '0;
    foreach (got[i]) pk = {pk[6:0], got[i]};
    check("r34_literal", pk, 8'h0C);
`endif
    run_pkt('{1, 1, 0}, 3, 3, 0);
    run_pkt(rbits(6), 1, 1, 0);
    check("r23_count", got.size(), 9 + (got.size() > 9 ? 9 : 0));
    run_pkt(rbits(300), 2, 2, 50);
    run_pkt(rbits(10), 0, 2, 0);
    run_pkt(rbits(9), 2, 0, 0);
    @(negedge clk);
    rate_i = 0;
    in_valid_i = 1;
    out_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      in_bit_i = bit'($urandom_range(1));
      @(negedge clk);
    end
    rst = 1;
    in_valid_i = 0;
    #1;
    check("midrst_ready", in_ready_o, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("midrst_valid", out_valid_o, 0);
    check("midrst_idle", in_ready_o, 1);
    run_pkt('{1, 0, 1, 1}, 0, 0, 0);
`ifndef CONV_TAIL_INSERT_EN
    pk = '0;
    foreach (got[i]) pk = {pk[6:0], got[i]};
    check("midrst_literal", pk, 8'hD1);
`endif
    for (int t = 0; t < 6; t++) run_pkt(rbits($urandom_range(1, 40)), $urandom_range(3), $urandom_range(3), t * 15);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_encoder_punct.md
# conv_encoder_punct

Parametrised rate-1/2 convolutional encoder for the 802.11a PHY transmit chain. It adds 2/3 and 3/4 puncturing, valid/ready flow control on both sides, per-packet framing, and optional automatic zero-tail termination. It sits between the scrambler and the interleaver and emits one coded bit per cycle as a serial stream.

## Interface
- K, default 7: constraint length; the shift register holds K-1 past bits.
- G0, default 7'o133: generator for coded bit A; width K; MSB taps the current input.
- G1, default 7'o171: generator for coded bit B; same format as G0.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- rate  in  2  puncturing mode: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 1/2. Sampled only on the first accepted bit of a packet.
- in_valid  in  1  input bit valid.
- in_ready  out  1  encoder can accept a bit this cycle.
- in_bit  in  1  data bit.
- in_last  in  1  marks the final data bit of a packet.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  coded bit.
- out_last  out  1  final coded bit of the packet.

## Operation
- Shift register d[1..K-1], where d[i] is the input accepted i bits ago.
- Coded bits:
  - A = XOR of (G0 & {x, d1..dK-1}).
  - B = same with G1.
  - Bit mapping: G bit K-1 ↔ x, G bit K-1-i ↔ d_i.
- Each accepted bit (data or tail) loads a 2-bit pair buffer {A, B} plus a keep mask. The serializer emits kept bits in order A then B.
- Puncturing phase counter p:
  - Reset to 0 at packet start.
  - Advances once per encoded bit and wraps at the period: 1 for rate 1/2, 2 for 2/3, 3 for 3/4.
- Keep masks:
  - 1/2: {A,B}.
  - 2/3: p0 {A,B}, p1 {A}.
  - 3/4: p0 {A,B}, p1 {A}, p2 {B}.
- States:
  - IDLE: shift register and p are zero; rate is latched on the first accepted bit, then → DATA.
  - DATA: accept bits. When the bit with in_last=1 is accepted → TAIL (macro on) or → DRAIN (macro off).
  - TAIL: internally encode K-1 zero bits, punctured normally, with in_ready=0. After the last tail bit is loaded → DRAIN.
  - DRAIN: in_ready=0 until the pair buffer empties; then clear the shift register and p, → IDLE.
- out_last is asserted with the final kept bit of the packet: the last tail bit's output if the macro is on, otherwise the last data bit's output.
- in_ready is high only in IDLE/DATA, and only when the buffer is empty or holds one bit that is being accepted this cycle (out_valid & out_ready).
- rst mid-packet: the packet is abandoned. The buffer, shift register, p and state are cleared, and no further bits of that packet are emitted.

## Timing
- Reset values: in_ready=0 during the rst cycle, then 1. out_valid=0, out_bit=0, out_last=0.
- Latency: a bit accepted at edge n produces out_valid=1 with its first kept bit after edge n (registered output).
- Throughput with out_ready held high:
  - Rate 1/2: 1 input per 2 cycles.
  - Rate 2/3: 2 inputs per 3 cycles.
  - Rate 3/4: 3 inputs per 4 cycles.
  - Zero bubble cycles on out_valid within a packet.
- out_bit and out_last hold stable while out_valid=1 and out_ready=0.
- Changes on rate during DATA/TAIL/DRAIN are ignored.
- The next packet may start in the cycle after out_last is accepted.

## Configuration
- CONV_TAIL_INSERT_EN defined: after in_last, K-1 zero tail bits are generated and encoded automatically, and the packet ends in the all-zero state.
- CONV_TAIL_INSERT_EN undefined: there is no TAIL state. The upstream block must supply tail bits as data. The shift register is still cleared in DRAIN.

## Test plan
- Rate 1/2, zero state, input 1,0,1,1 (last on the 4th), macro off, out_ready=1 → out_bit 1,1,0,1,0,0,0,1; out_last on the 8th bit; then the FSM returns to IDLE.
- Rate 3/4, input 1,0,1 (last), macro off → out_bit 1,1,0,0; out_last on the 4th bit.
- Rate 2/3, 6 random bits, macro on → 9 data-coded bits, then 9 tail-coded bits (6 tail bits × 1.5). All 18 outputs match the reference model, and the state ends at zero.
- Random out_ready toggling (50%) at rate 3/4 over 300 bits → output identical to the stall-free run; out_bit stable during stalls; in_ready never high with a full buffer.
- rate changed mid-packet from 0 to 2 → puncturing stays 1/2 until out_last; the next packet uses 3/4.
- rst pulsed for one cycle mid-packet → next cycle out_valid=0 and the FSM is in IDLE; a new packet 1,0,1,1 reproduces the first scenario's output exactly.
